// File: rtl/rf_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_sb_if
//  Description : Bus bundle for the rf_sb register file / scoreboard.
//                Groups the read ports, reservation port, write-back port
//                and scoreboard vector.
//                master : issuing/control side (drives requests, sees results)
//                slave  : rf_sb itself
//  Ports       : rs_en/rs_addr -> rs_val/rs_hazard (per read port),
//                rsv_en/rsv_addr, wb_en/wb_addr/wb_sel + result sources,
//                busy (scoreboard vector)
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD-1:0]      rs_en;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_val;
    logic [NREAD-1:0]      rs_hazard;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [1:0]            wb_sel;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       load_result;
    logic [XLEN-1:0]       csr_val;
    logic [NREGS-1:0]      busy;

    modport master (
        output rs_en, rs_addr, rsv_en, rsv_addr, wb_en, wb_addr, wb_sel,
               alu_result, load_result, csr_val,
        input  rs_val, rs_hazard, busy
    );

    modport slave (
        input  rs_en, rs_addr, rsv_en, rsv_addr, wb_en, wb_addr, wb_sel,
               alu_result, load_result, csr_val,
        output rs_val, rs_hazard, busy
    );
endinterface
`default_nettype wire

// File: rtl/rf_sb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_sb
//  Description : Parametrised integer register file with write-back source
//                mux, same-cycle write-to-read bypass and a per-register
//                pending (busy) scoreboard for RAW hazard detection.
//  Ports       : clk    - core clock, all state on rising edge
//                rst_n  - synchronous active-low reset
//                bus    - rf_sb_if.slave (read ports, reservation,
//                         write-back, busy vector)
//  Revision    : 1.0  initial release
// ============================================================================
module rf_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    rf_sb_if.slave    bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]       r_regs [NREGS];
    logic [NREGS-1:0]      r_busy;
    logic [NREAD*XLEN-1:0] r_rs_val;
    logic [NREAD-1:0]      r_rs_hazard;

    logic [XLEN-1:0]       w_wb_data;
    logic                  w_wb_we;
    logic [XLEN-1:0]       w_rd_data [NREAD];
    logic [NREAD-1:0]      w_rd_haz;

    // Write-back source mux; 11 aliases to the ALU result.
    always_comb begin
        w_wb_data = bus.alu_result;
        case (bus.wb_sel)
            2'b01:   w_wb_data = bus.load_result;
            2'b10:   w_wb_data = bus.csr_val;
            default: w_wb_data = bus.alu_result;
        endcase
    end

    // Writes to x0 are dropped here, so x0 never leaves its reset value.
    assign w_wb_we = bus.wb_en && (bus.wb_addr != '0);

    // Per-port read path: bypass from the write-back mux, x0 forced to zero.
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] w_addr;
        logic          w_hit;

        assign w_addr = bus.rs_addr[p*AW +: AW];
        assign w_hit  = w_wb_we && (bus.wb_addr == w_addr);

        assign w_rd_data[p] = w_hit            ? w_wb_data :
                              (w_addr == '0)   ? '0        :
                                                 r_regs[w_addr];

        // A same-cycle write-back clears the hazard; a same-cycle reservation
        // does not raise one because r_busy only reflects past edges.
        assign w_rd_haz[p] = bus.rs_en[p] && r_busy[w_addr] &&
                             !(bus.wb_en && (bus.wb_addr == w_addr));
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[bus.wb_addr] <= w_wb_data;
        end
    end

    // Scoreboard. Reservation outranks write-back to the same register: the
    // newer instruction owns the destination. Bit 0 is never set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (bus.rsv_en && (bus.rsv_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (bus.wb_en && (bus.wb_addr == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Registered read outputs; a disabled port drives zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs_val    <= '0;
            r_rs_hazard <= '0;
        end else begin
            for (int p = 0; p < NREAD; p++) begin
                r_rs_val[p*XLEN +: XLEN] <= bus.rs_en[p] ? w_rd_data[p] : '0;
            end
            r_rs_hazard <= w_rd_haz;
        end
    end

    assign bus.rs_val    = r_rs_val;
    assign bus.rs_hazard = r_rs_hazard;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_rf_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_sb
//  Description : Directed self-checking bench for rf_sb. Instance u_a is the
//                default RV32I / 2-port build, u_b the RV32E / 3-port build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_sb;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rf_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_a ();
    rf_sb_if #(.XLEN(32), .NREGS(16), .NREAD(3)) bus_b ();

    rf_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    rf_sb #(.XLEN(32), .NREGS(16), .NREAD(3)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.rs_en = '0; bus_a.rs_addr = '0;
        bus_a.rsv_en = 1'b0; bus_a.rsv_addr = '0;
        bus_a.wb_en = 1'b0; bus_a.wb_addr = '0; bus_a.wb_sel = 2'b00;
        bus_a.alu_result = '0; bus_a.load_result = '0; bus_a.csr_val = '0;
    endtask

    task automatic idle_b();
        bus_b.rs_en = '0; bus_b.rs_addr = '0;
        bus_b.rsv_en = 1'b0; bus_b.rsv_addr = '0;
        bus_b.wb_en = 1'b0; bus_b.wb_addr = '0; bus_b.wb_sel = 2'b00;
        bus_b.alu_result = '0; bus_b.load_result = '0; bus_b.csr_val = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        idle_a();
        idle_b();
        tick();
        tick();
        chk("reset_rs_val0", bus_a.rs_val[31:0], 32'h0);
        chk("reset_busy", bus_a.busy, 32'h0);

        // Reset scrub: x5 <- DEADBEEF, confirm, then reset and re-read.
        rst_n = 1'b1;
        bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd5; bus_a.wb_sel = 2'b00;
        bus_a.alu_result = 32'hDEADBEEF;
        tick();
        idle_a();
        bus_a.rs_en = 2'b01; bus_a.rs_addr = {5'd0, 5'd5};
        tick();
        chk("x5_written", bus_a.rs_val[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        tick();
        chk("reset_clears_rs_val", bus_a.rs_val[31:0], 32'h0);
        rst_n = 1'b1;
        tick();
        chk("scrub_x5", bus_a.rs_val[31:0], 32'h0);
        chk("scrub_busy", bus_a.busy, 32'h0);

        // Load write-back to x7, read on both ports the next cycle.
        idle_a();
        bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd7; bus_a.wb_sel = 2'b01;
        bus_a.alu_result = 32'h0BAD0BAD; bus_a.load_result = 32'h12345678;
        bus_a.csr_val = 32'hC5C5C5C5;
        tick();
        idle_a();
        bus_a.rs_en = 2'b11; bus_a.rs_addr = {5'd7, 5'd7};
        tick();
        chk("x7_port0", bus_a.rs_val[31:0], 32'h12345678);
        chk("x7_port1", bus_a.rs_val[63:32], 32'h12345678);

        // Write to x0 is discarded, including through the bypass.
        idle_a();
        bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd0; bus_a.alu_result = 32'hFFFFFFFF;
        bus_a.rs_en = 2'b01; bus_a.rs_addr = {5'd0, 5'd0};
        tick();
        chk("x0_bypass", bus_a.rs_val[31:0], 32'h0);
        idle_a();
        bus_a.rs_en = 2'b01;
        tick();
        chk("x0_storage", bus_a.rs_val[31:0], 32'h0);

        // Bypass: CSR write-back to x3 read on port 1 in the same cycle.
        idle_a();
        bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd3; bus_a.wb_sel = 2'b10;
        bus_a.csr_val = 32'hA5A5A5A5; bus_a.alu_result = 32'h11111111;
        bus_a.rs_en = 2'b10; bus_a.rs_addr = {5'd3, 5'd3};
        tick();
        chk("bypass_x3_val1", bus_a.rs_val[63:32], 32'hA5A5A5A5);
        chk("bypass_x3_haz1", 32'(bus_a.rs_hazard[1]), 32'h0);
        chk("disabled_port0", bus_a.rs_val[31:0], 32'h0);

        // Scoreboard: reserve x9, read it next cycle.
        idle_a();
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd9;
        tick();
        idle_a();
        bus_a.rs_en = 2'b01; bus_a.rs_addr = {5'd0, 5'd9};
        tick();
        chk("x9_hazard", 32'(bus_a.rs_hazard[0]), 32'h1);
        chk("x9_busy", bus_a.busy, 32'h0000_0200);

        // Write-back to x9 with a simultaneous read resolves the hazard.
        bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd9; bus_a.wb_sel = 2'b11;
        bus_a.alu_result = 32'h55;
        tick();
        chk("x9_wb_hazard", 32'(bus_a.rs_hazard[0]), 32'h0);
        chk("x9_wb_val", bus_a.rs_val[31:0], 32'h55);
        chk("x9_wb_busy", bus_a.busy, 32'h0);

        // Reservation in the same cycle as a read raises no hazard yet.
        idle_a();
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd10;
        bus_a.rs_en = 2'b01; bus_a.rs_addr = {5'd0, 5'd10};
        tick();
        chk("rsv_same_cycle_haz", 32'(bus_a.rs_hazard[0]), 32'h0);
        chk("rsv_x10_busy", bus_a.busy, 32'h0000_0400);

        // Collision on x4: reservation beats the write-back, data still lands.
        idle_a();
        bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd10;   // retire x10
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd4;
        tick();
        chk("x4_reserved", bus_a.busy, 32'h0000_0010);
        idle_a();
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd4;
        bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd4; bus_a.alu_result = 32'h11;
        tick();
        chk("collision_busy", bus_a.busy, 32'h0000_0010);
        idle_a();
        bus_a.rs_en = 2'b01; bus_a.rs_addr = {5'd0, 5'd4};
        tick();
        chk("collision_val", bus_a.rs_val[31:0], 32'h11);
        chk("collision_haz", 32'(bus_a.rs_hazard[0]), 32'h1);
        idle_a();

        // RV32E / 3-port build.
        bus_b.wb_en = 1'b1; bus_b.wb_addr = 4'd15; bus_b.wb_sel = 2'b00;
        bus_b.alu_result = 32'h7;
        tick();
        idle_b();
        bus_b.rs_en = 3'b111; bus_b.rs_addr = {4'd15, 4'd0, 4'd15};
        tick();
        chk("e_port0_x15", bus_b.rs_val[31:0], 32'h7);
        chk("e_port1_x0", bus_b.rs_val[63:32], 32'h0);
        chk("e_port2_x15", bus_b.rs_val[95:64], 32'h7);
        bus_b.rs_en = 3'b101; bus_b.rs_addr = {4'd15, 4'd15, 4'd15};
        tick();
        chk("e_port1_disabled", bus_b.rs_val[63:32], 32'h0);
        chk("e_port2_enabled", bus_b.rs_val[95:64], 32'h7);
        bus_b.rs_en = 3'b000;
        tick();
        chk("e_port0_disabled", bus_b.rs_val[31:0], 32'h0);
        chk("e_port2_disabled", bus_b.rs_val[95:64], 32'h0);
        chk("e_busy", 32'(bus_b.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rf_sb.md
# rf_sb

Parametrised integer register file with an integrated write-back scoreboard. It is the successor to the fixed 32×32, two-read-port register file of the core. It adds:
- configurable XLEN, register count (RV32I/RV32E) and read-port count;
- a write-back source mux;
- same-cycle write-to-read bypass;
- per-register pending (busy) tracking, so the control FSM can issue a new instruction while a load or CSR result is still outstanding and stall only on a true RAW hazard.

## Interface

Reset is synchronous and active-low. There is one clock.

Parameters:
- XLEN, 32, register and datapath width.
- NREGS, 32, number of architectural registers. Legal values are 16 (RV32E) or 32.
- NREAD, 2, number of read ports. Legal range is 1..4.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- rs_en  in  NREAD  per-port read enable.
- rs_addr  in  NREAD*AW  per-port read address; port p occupies bits [p*AW +: AW].
- rs_val  out  NREAD*XLEN  registered read data, one slice per port.
- rs_hazard  out  NREAD  registered per-port flag: the register read on that port was still pending.
- rsv_en  in  1  reserve a destination, marking it pending.
- rsv_addr  in  AW  register to reserve.
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back destination.
- wb_sel  in  2  result source: 00 ALU, 01 load, 10 CSR, 11 ALU.
- alu_result  in  XLEN  ALU result.
- load_result  in  XLEN  load result.
- csr_val  in  XLEN  CSR read value.
- busy  out  NREGS  current scoreboard vector; bit i means register i is pending.

## Operation

- **Storage:** NREGS×XLEN flops.
- **x0:**
  - Register 0 always reads 0.
  - Writes to x0 are discarded.
  - busy[0] is constant 0; rsv_en with rsv_addr==0 is ignored.
- **Write:** with wb_en and wb_addr≠0, register[wb_addr] takes the value selected by wb_sel.
- **Read, per port p:**
  - With rs_en[p]=0: rs_val slice ← 0 and rs_hazard[p] ← 0.
  - Otherwise rs_val slice ← bypassed value of register[rs_addr_p].
  - Bypass rule: if wb_en, wb_addr==rs_addr_p and the address is nonzero in the same cycle, the port returns the mux output, not the stale register contents.
- **Hazard, per port p:** rs_hazard[p] ← rs_en[p] & busy[rs_addr_p] & ~(wb_en & wb_addr==rs_addr_p).
  - A write-back in the same cycle resolves the hazard.
  - A reservation in the same cycle does not create one; the reservation is visible from the next cycle.
- **Scoreboard, per register i≠0, next-state priority:**
  1. rsv_en & rsv_addr==i → busy[i]=1. When it coincides with a write-back to the same register, the newer instruction owns the register, so the reservation wins.
  2. Else wb_en & wb_addr==i → busy[i]=0.
  3. Else hold.
- **Write-back to a non-busy register** is legal: the data is written and busy stays 0.
- **Address range:** when NREGS=16 (AW=4), every address is in range; no out-of-range handling is needed.
- **Ports are independent:** all ports may read the same address in the same cycle.

## Timing

- **Read latency:** 1 cycle. Address and enable are sampled at edge N; rs_val and rs_hazard are valid after edge N and held until the next edge.
- rs_val and rs_hazard update every cycle. There is no hold-on-disable; a disabled port drives 0.
- **Write latency:** register contents update at edge N. A read issued at edge N sees the new data through the bypass. A read at N+1 sees it from storage.
- **busy:** direct flop output, updated at the edge where rsv_en or wb_en is sampled. It is combinationally independent of the current inputs.
- **Reset:** at a rising edge with rst_n=0, every register, rs_val, rs_hazard and busy is set to 0. Reset has priority over all same-cycle rsv, wb and read activity, and any pending write-back is discarded.

## Test plan

- **Reset scrub:** write 0xDEADBEEF to x5 (wb_sel=00), then assert rst_n=0 for one cycle, then read x5 on port 0. Required: rs_val0=0, busy=0.
- **Write/read and x0:**
  - wb x7←0x12345678 via load (wb_sel=01); next cycle read x7 on both ports. Required: both ports return 0x12345678.
  - wb x0←0xFFFFFFFF; read x0. Required: 0.
- **Bypass:** in the same cycle, wb x3←0xA5A5A5A5 (csr_val, wb_sel=10) and read x3 on port 1. Required: rs_val1=0xA5A5A5A5 after that edge, rs_hazard1=0.
- **Scoreboard hazard:**
  - rsv x9; next cycle read x9. Required: rs_hazard0=1, busy[9]=1.
  - wb x9←0x55 on the following cycle with a simultaneous read of x9. Required: rs_hazard0=0, rs_val0=0x55, busy[9]=0.
- **Reserve vs write-back collision:** with x4 busy, apply rsv x4 and wb x4←0x11 in the same cycle. Required:
  - busy[4] stays 1;
  - the register holds 0x11;
  - a read the next cycle gives rs_hazard=1.
- **RV32E/NREAD configuration:** with NREGS=16 and NREAD=3, write x15←0x7, then read x15, x0 and x15 on ports 0..2. Required: values 0x7, 0, 0x7; rs_en=0 on any port gives 0.
